// File: rtl/io_pattern_checker_pkg.sv
// Shared types and helpers for the IO pattern checker.
// masked_eq works on buses up to MASKED_EQ_W bits wide; callers zero-extend.
package io_pattern_checker_pkg;

  localparam int MASKED_EQ_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    PASS,
    FAIL
  } chk_state_t;

  function automatic logic masked_eq(input logic [MASKED_EQ_W-1:0] data,
                                     input logic [MASKED_EQ_W-1:0] mask,
                                     input logic [MASKED_EQ_W-1:0] bus);
    return ((bus ^ data) & mask) == '0;
  endfunction

endpackage

// File: rtl/io_pattern_buf.sv
// Expectation store: DEPTH data+mask entries, append-only while allowed, indexed read.
// Writes land in one cycle; writes while not allowed or full are dropped and flagged sticky.
module io_pattern_buf #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_allow,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [WIDTH-1:0]           wr_mask,
  input  logic [$clog2(DEPTH+1)-1:0] rd_idx,
  output logic [WIDTH-1:0]           rd_data,
  output logic [WIDTH-1:0]           rd_mask,
  output logic [$clog2(DEPTH+1)-1:0] wr_ptr,
  output logic                       full,
  output logic                       overflow
);

  localparam int IW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [WIDTH-1:0] mask_mem [DEPTH];

  assign full = (wr_ptr == IW'(DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        mask_mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      if (wr_allow && !full) begin
        data_mem[wr_ptr[AW-1:0]] <= wr_data;
        mask_mem[wr_ptr[AW-1:0]] <= wr_mask;
        wr_ptr                   <= wr_ptr + IW'(1);
      end else begin
        overflow <= 1'b1;
      end
    end
  end

  // Index DEPTH is reachable once every entry is accepted; read zeros there.
  always_comb begin
    rd_data = '0;
    rd_mask = '0;
    if (rd_idx < IW'(DEPTH)) begin
      rd_data = data_mem[rd_idx[AW-1:0]];
      rd_mask = mask_mem[rd_idx[AW-1:0]];
    end
  end

endmodule

// File: rtl/io_pattern_checker.sv
// Follows the synchronised IO bus through an ordered list of masked patterns; ends in PASS or FAIL.
// Input-to-comparator latency 2 cycles, acceptance after STABLE_CYCLES matching cycles; no backpressure.
module io_pattern_checker
  import io_pattern_checker_pkg::*;
#(
  parameter int WIDTH          = 34,
  parameter int DEPTH          = 8,
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [WIDTH-1:0]                    io_in,
  input  logic                                exp_wr_en,
  input  logic [WIDTH-1:0]                    exp_wr_data,
  input  logic [WIDTH-1:0]                    exp_wr_mask,
  input  logic                                start,
  input  logic                                clear,
  output logic                                busy,
  output logic                                pass,
  output logic                                fail,
  output logic                                exp_full,
  output logic                                exp_overflow,
  output logic [$clog2(DEPTH+1)-1:0]          match_idx,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] cycle_count
);

  localparam int IW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  chk_state_t       state, state_nxt;
  logic [WIDTH-1:0] sync_q, io_sync;
  logic [WIDTH-1:0] rd_data, rd_mask;
  logic [IW-1:0]    wr_ptr;
  logic [SW-1:0]    stab_cnt;
  logic             hit, accept, last, timed_out;

  io_pattern_buf #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_buf (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .wr_allow (state == IDLE),
    .wr_en    (exp_wr_en),
    .wr_data  (exp_wr_data),
    .wr_mask  (exp_wr_mask),
    .rd_idx   (match_idx),
    .rd_data  (rd_data),
    .rd_mask  (rd_mask),
    .wr_ptr   (wr_ptr),
    .full     (exp_full),
    .overflow (exp_overflow)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= '0;
      io_sync <= '0;
    end else begin
      sync_q  <= io_in;
      io_sync <= sync_q;
    end
  end

  assign hit       = masked_eq(MASKED_EQ_W'(rd_data), MASKED_EQ_W'(rd_mask), MASKED_EQ_W'(io_sync));
  assign accept    = (state == CHECK) && hit && (stab_cnt == SW'(STABLE_CYCLES - 1));
  assign last      = (match_idx == wr_ptr - IW'(1));
  assign timed_out = (cycle_count == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Final acceptance is tested before the timeout so PASS wins a tie.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    pass      = 1'b0;
    fail      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (wr_ptr == '0) ? PASS : CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (accept && last) state_nxt = PASS;
        else if (timed_out) state_nxt = FAIL;
      end
      PASS:    pass = 1'b1;
      FAIL:    fail = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      match_idx   <= '0;
      stab_cnt    <= '0;
      cycle_count <= '0;
    end else if (state == IDLE && start) begin
      match_idx   <= '0;
      stab_cnt    <= '0;
      cycle_count <= '0;
    end else if (state == CHECK) begin
      if (!timed_out) cycle_count <= cycle_count + CW'(1);
      if (accept) begin
        match_idx <= match_idx + IW'(1);
        stab_cnt  <= '0;
      end else if (hit) begin
        stab_cnt <= stab_cnt + SW'(1);
      end else begin
        stab_cnt <= '0;
      end
    end
  end

endmodule
